// File: rtl/code_converter_unit_if.sv
// code_converter_unit_if: word/select/valid request and registered result bundle
interface code_converter_unit_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] code_in;
    logic [WIDTH-1:0] code_out;
    logic [1:0] select;
    logic in_valid;
    logic out_valid;
    logic code_err;
    modport master(output code_in, select, in_valid, input code_out, out_valid, code_err);
    modport slave(input code_in, select, in_valid, output code_out, out_valid, code_err);
endinterface

// File: rtl/code_converter_unit.sv
// code_converter_unit: 1-cycle registered bin/Gray/BCD/XS3 converter
// optional BCD/XS3 range check compiled in by CODE_CONV_RANGE_CHECK_EN
module code_converter_unit #(parameter int WIDTH = 4) (
    input logic clk,
    input logic rst,
    code_converter_unit_if.slave bus
);
    logic [WIDTH-1:0] b2g, g2b, f_out;
    logic bcd_bad, xs3_bad, f_err;
    assign b2g = bus.code_in ^ (bus.code_in >> 1);
    // each binary bit is the parity of all Gray bits at or above it
    for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
        assign g2b[i] = ^bus.code_in[WIDTH-1:i];
    end
`ifdef CODE_CONV_RANGE_CHECK_EN
    assign bcd_bad = bus.code_in > WIDTH'(9);
    assign xs3_bad = (bus.code_in < WIDTH'(3)) || (bus.code_in > WIDTH'(12));
`else
    assign bcd_bad = 1'b0;
    assign xs3_bad = 1'b0;
`endif
    always_comb begin
        f_err = bus.select == 2'd1 ? bcd_bad : bus.select == 2'd3 ? xs3_bad : 1'b0;
        f_out = f_err ? '0 :
                bus.select == 2'd0 ? b2g :
                bus.select == 2'd1 ? bus.code_in + WIDTH'(3) :
                bus.select == 2'd2 ? g2b : bus.code_in - WIDTH'(3);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.code_out <= '0;
            bus.code_err <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.code_out <= f_out;
                bus.code_err <= f_err;
            end
        end
    end
endmodule

// File: tb/tb_code_converter_unit.sv
// tb_code_converter_unit: scoreboard bench for code_converter_unit
module tb_code_converter_unit;
    typedef struct packed {
        logic err;
        logic [3:0] out;
    } exp_t;
    logic clk = 0;
    logic rst = 1;
    int n_tests = 0;
    int n_fail = 0;
    exp_t sb[$];
    exp_t e;
    logic exp_valid = 0;
    logic [3:0] last_out = 0;
    logic last_err = 0;
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    code_converter_unit_if #(.WIDTH(4)) bus();
    code_converter_unit #(.WIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(logic [3:0] c, logic [1:0] s);
        exp_t r;
        r = '0;
        case (s)
            2'd0: r.out = gray_tab[c];
            2'd1: begin
`ifdef CODE_CONV_RANGE_CHECK_EN
                if (c > 4'd9) r.err = 1'b1; else r.out = c + 4'd3;
`else
                r.out = c + 4'd3;
`endif
            end
            2'd2: for (int k = 0; k < 16; k++) if (gray_tab[k] == c) r.out = 4'(k);
            default: begin
`ifdef CODE_CONV_RANGE_CHECK_EN
                if (c < 4'd3 || c > 4'd12) r.err = 1'b1; else r.out = c - 4'd3;
`else
                r.out = c - 4'd3;
`endif
            end
        endcase
        return r;
    endfunction
    task automatic send(logic [3:0] c, logic [1:0] s);
        bus.code_in = c;
        bus.select = s;
        bus.in_valid = 1'b1;
        sb.push_back(model(c, s));
        @(posedge clk);
        #1;
    endtask
    task automatic idle(int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask
    always @(posedge clk) exp_valid = !rst && bus.in_valid;
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("code_out", 32'(bus.code_out), 32'(e.out));
                    check("code_err", 32'(bus.code_err), 32'(e.err));
                    last_out = e.out;
                    last_err = e.err;
                end
            end else begin
                check("hold_out", 32'(bus.code_out), 32'(last_out));
                check("hold_err", 32'(bus.code_err), 32'(last_err));
            end
        end
    end
    initial begin
        bus.code_in = '0;
        bus.select = '0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(bus.code_out), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_err", 32'(bus.code_err), 32'd0);
        rst = 1'b0;
        idle(1);
        for (int i = 0; i < 16; i++) send(4'(i), 2'd0);
        for (int i = 0; i < 16; i++) send(4'(i), 2'd1);
        for (int i = 0; i < 16; i++) send(gray_tab[i], 2'd2);
        for (int i = 0; i < 16; i++) send(4'(i), 2'd3);
        send(4'b1011, 2'd0);
        idle(2);
        send(4'b1000, 2'd0);
        send(4'b1000, 2'd3);
        send(4'b0101, 2'd1);
        idle(1);
        send(4'b0110, 2'd0);
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out", 32'(bus.code_out), 32'd0);
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_err", 32'(bus.code_err), 32'd0);
        sb.delete();
        last_out = 4'd0;
        last_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        send(4'b1101, 2'd1);
        send(4'b0000, 2'd3);
        idle(2);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/code_converter_unit.md
Name: code_converter_unit

Overview:
- 4-bit registered code converter; select chooses one of four conversions: binary→Gray, BCD→Excess-3, Gray→binary, Excess-3→binary.
- Sits in the datapath between code sources and consumers; accepts one word per cycle with a valid strobe and returns the result one clock later.
- Range checking on BCD/Excess-3 inputs is optional, compiled in by macro.

Parameters:
- WIDTH, 4, code word width; the Excess-3 modes and the range check are defined only for 4, and the Gray modes must scale to any WIDTH ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- code_in  input  WIDTH  input code word
- select  input  2  conversion select: 00 bin→Gray, 01 BCD→XS3, 10 Gray→bin, 11 XS3→bin
- in_valid  input  1  code_in/select qualifier
- code_out  output  WIDTH  converted word, registered
- out_valid  output  1  code_out valid, one cycle after in_valid
- code_err  output  1  input outside legal range for the selected mode; coincident with out_valid

Behaviour:
- Reset (async assert, synchronous release on clk): code_out=0, out_valid=0, code_err=0.
- Latency fixed at 1 cycle.
  - On each rising edge with in_valid=1: code_out, code_err ← f(select, code_in) and out_valid ← 1.
  - On an edge with in_valid=0: out_valid ← 0; code_out and code_err hold their last values.
- No backpressure: every valid input is accepted, and back-to-back inputs give back-to-back outputs.
- select is sampled with code_in on the same edge; changing select between words has no side effects.
- Conversion function f:
  - 00 bin→Gray: out = in XOR (in >> 1). Example: 1011 → 1110.
  - 01 BCD→XS3: out = in + 3 (mod 16). Example: 0101 → 1000.
  - 10 Gray→bin: out[MSB] = in[MSB]; out[i] = out[i+1] XOR in[i], down to bit 0. Example: 1110 → 1011.
  - 11 XS3→bin: out = in − 3 (mod 16). Example: 1000 → 0101.
- Gray modes accept all 16 codes, never flag an error, and are exact inverses of each other.
- Wrap-around (macro absent):
  - BCD 1101 → XS3 0000; BCD 1111 → 0010.
  - XS3 0000 → 1101; XS3 0010 → 1111.
- Reset asserted mid-stream clears all outputs immediately. The first valid input after release produces output on the following edge.

Optional Feature:
- Macro CODE_CONV_RANGE_CHECK_EN.
- Defined:
  - mode 01 with code_in > 1001: code_out=0000, code_err=1.
  - mode 11 with code_in < 0011 or > 1100: code_out=0000, code_err=1.
  - All legal inputs, and both Gray modes: code_err=0.
- Not defined: code_err is tied to 0; modes 01/11 wrap mod 16 as specified in Behaviour.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out_valid=1 → code_out=0, out_valid=0, code_err=0 without waiting for a clock edge.
- Mode 00 sweep: code_in runs 0000..1111, in_valid=1 every cycle.
  - Outputs one cycle later: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
  - out_valid stays 1 throughout.
- Mode 01 sweep, 0000..1111:
  - 0000..1001 → 0011..1100.
  - 1010..1111: with macro, 0000 and code_err=1; without macro, 1101,1110,1111,0000,0001,0010 and code_err=0.
- Mode 10 sweep: feed the mode-00 outputs as code_in → code_out returns 0000..1111 in order. Round trip bin→Gray→bin is identity for all 16 values.
- Mode 11 sweep, 0000..1111:
  - 0011..1100 → 0000..1001.
  - 0000 → 1101 without macro; with macro, 0000 and code_err=1.
  - 1111: with macro, code_err=1; without macro, 1100.
- Gaps and select switching:
  - Drop in_valid for 2 cycles → out_valid=0 and code_out holds its value.
  - Switch select 00→11 on consecutive cycles with code_in=1000 → outputs 1100, then 0101.
